// File: rtl/rs_enc_sequencer.sv
// Frame sequencer for a systematic RS encoder: streams K message symbols through,
// then drains N-K parity symbols from the LFSR, with full output backpressure.
module rs_enc_sequencer #(
  parameter int SYM_W = 8,
  parameter int N     = 15,
  parameter int K     = 11,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [SYM_W-1:0] in_data,
  output logic             in_ready,
  output logic             enc_en,
  output logic             enc_first,
  output logic [SYM_W-1:0] enc_din,
  output logic             enc_shift,
  input  logic [SYM_W-1:0] enc_par,
  output logic             out_valid,
  output logic [SYM_W-1:0] out_data,
  output logic             out_sop,
  output logic             out_eop,
  input  logic             out_ready,
  output logic             busy,
  output logic [15:0]      cw_count
);

  typedef enum logic [1:0] {IDLE = 2'd0, MSG = 2'd1, PAR = 2'd2} state_t;

  localparam logic [CNT_W-1:0] MSG_LAST = CNT_W'(K - 1);
  localparam logic [CNT_W-1:0] PAR_LAST = CNT_W'(N - K - 1);
  localparam bit               ONE_MSG  = (K == 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               out_valid_q, out_valid_d;
  logic [SYM_W-1:0]   out_data_q, out_data_d;
  logic               out_sop_q, out_sop_d;
  logic               out_eop_q, out_eop_d;
  logic [15:0]        cw_count_q, cw_count_d;
  logic               stall_s;
  logic               acc_s;

  // Handshake and LFSR controls are combinational so the LFSR never moves while stalled
  assign stall_s   = out_valid_q & ~out_ready;
  assign in_ready  = ~stall_s & ((state_q == IDLE) | (state_q == MSG));
  assign acc_s     = in_valid & in_ready;
  assign enc_en    = acc_s;
  assign enc_din   = in_data;
  assign enc_first = acc_s & (state_q == IDLE);
  assign enc_shift = (state_q == PAR) & ~stall_s;
  assign busy      = (state_q != IDLE);

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sop   = out_sop_q;
  assign out_eop   = out_eop_q;
  assign cw_count  = cw_count_q;

  // Next-state, counter and output-register load decisions
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sop_d   = out_sop_q;
    out_eop_d   = out_eop_q;
    cw_count_d  = cw_count_q;
    case (state_q)
      IDLE: begin
        if (acc_s) begin
          out_data_d  = in_data;
          out_sop_d   = 1'b1;
          out_eop_d   = 1'b0;
          out_valid_d = 1'b1;
          // K==1 skips MSG; the counter then indexes parity from zero
          if (ONE_MSG) begin
            cnt_d   = {CNT_W{1'b0}};
            state_d = PAR;
          end else begin
            cnt_d   = CNT_W'(1);
            state_d = MSG;
          end
        end else if (!stall_s) begin
          out_valid_d = 1'b0;
        end else begin
          out_valid_d = out_valid_q;
        end
      end
      MSG: begin
        if (acc_s) begin
          out_data_d  = in_data;
          out_sop_d   = 1'b0;
          out_eop_d   = 1'b0;
          out_valid_d = 1'b1;
          if (cnt_q == MSG_LAST) begin
            cnt_d   = {CNT_W{1'b0}};
            state_d = PAR;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (!stall_s) begin
          out_valid_d = 1'b0;
        end else begin
          out_valid_d = out_valid_q;
        end
      end
      PAR: begin
        if (!stall_s) begin
          out_data_d  = enc_par;
          out_sop_d   = 1'b0;
          out_eop_d   = (cnt_q == PAR_LAST);
          out_valid_d = 1'b1;
          if (cnt_q == PAR_LAST) begin
            cnt_d      = {CNT_W{1'b0}};
            cw_count_d = cw_count_q + 16'd1;
            state_d    = IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State, counter and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      out_valid_q <= 1'b0;
      out_data_q  <= {SYM_W{1'b0}};
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      cw_count_q  <= 16'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      cw_count_q  <= cw_count_d;
    end
  end

endmodule

// File: tb/tb_rs_enc_sequencer.sv
// Scoreboard bench for rs_enc_sequencer: expected beats are queued at stimulus time
// and popped as the DUT hands symbols downstream; a stub LFSR yields 0xA1.. per shift.
module tb_rs_enc_sequencer;
  localparam int SYM_W = 8;
  localparam int N     = 15;
  localparam int K     = 11;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [SYM_W-1:0] in_data;
  logic             in_ready;
  logic             enc_en, enc_first, enc_shift;
  logic [SYM_W-1:0] enc_din, enc_par;
  logic             out_valid, out_sop, out_eop, out_ready;
  logic [SYM_W-1:0] out_data;
  logic             busy;
  logic [15:0]      cw_count;

  rs_enc_sequencer #(.SYM_W(SYM_W), .N(N), .K(K), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .enc_en(enc_en), .enc_first(enc_first), .enc_din(enc_din), .enc_shift(enc_shift),
    .enc_par(enc_par), .out_valid(out_valid), .out_data(out_data), .out_sop(out_sop),
    .out_eop(out_eop), .out_ready(out_ready), .busy(busy), .cw_count(cw_count)
  );

  always #5 clk = ~clk;

  int          check_cnt = 0;
  int          err_cnt   = 0;
  logic [9:0]  exp_q[$];
  int          sop_cyc_q[$];
  int          eop_cyc_q[$];
  int          first_at_q[$];
  int          en_cnt = 0, fi_cnt = 0, sh_cnt = 0, cyc = 0;
  logic [7:0]  par_idx;
  bit          bp_mode = 1'b0;

  assign enc_par = 8'hA1 + par_idx;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Monitor, stub LFSR and downstream backpressure, all on the falling edge
  initial begin
    bit pend_first = 1'b0, pend_shift = 1'b0, prev_stall = 1'b0;
    bit s5 = 1'b0, s12 = 1'b0;
    int pos = 0, stall_left = 0;
    par_idx   = 8'd0;
    out_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (pend_first) par_idx = 8'd0;
      else if (pend_shift) par_idx = par_idx + 8'd1;
      if (bp_mode && pos == 5 && !s5) begin s5 = 1'b1; stall_left = 3; end
      if (bp_mode && pos == 12 && !s12) begin s12 = 1'b1; stall_left = 3; end
      out_ready = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      #1;
      cyc++;
      pend_first = enc_en & enc_first;
      pend_shift = enc_shift;
      if (enc_en) begin
        check_eq("enc_din", {24'd0, enc_din}, {24'd0, in_data});
        if (enc_first) first_at_q.push_back(en_cnt + sh_cnt);
        en_cnt++;
      end
      if (enc_first) fi_cnt++;
      if (enc_shift) sh_cnt++;
      if (prev_stall) check_eq("hold_valid", {31'd0, out_valid}, 32'd1);
      if (out_valid && !out_ready) begin
        check_eq("stall_in_ready", {31'd0, in_ready}, 32'd0);
        check_eq("stall_enc_en", {31'd0, enc_en}, 32'd0);
        check_eq("stall_enc_shift", {31'd0, enc_shift}, 32'd0);
      end
      prev_stall = out_valid & ~out_ready;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_beat", {22'd0, out_data, out_sop, out_eop}, 32'hFFFF);
        end else begin
          check_eq("beat", {22'd0, out_data, out_sop, out_eop}, {22'd0, exp_q[0]});
          if (out_ready) begin
            void'(exp_q.pop_front());
            if (out_sop) sop_cyc_q.push_back(cyc);
            if (out_eop) begin
              eop_cyc_q.push_back(cyc);
              pos = 0; s5 = 1'b0; s12 = 1'b0;
            end else begin
              pos++;
            end
          end
        end
      end
    end
  end

  task automatic send_sym(input logic [7:0] d);
    bit done = 1'b0;
    int guard = 0;
    while (!done) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = d;
      #2;
      done = in_ready;
      guard++;
      if (guard > 200) begin
        check_eq("accept_timeout", 32'd1, 32'd0);
        done = 1'b1;
      end
      @(posedge clk);
    end
  endtask

  task automatic push_cw(input logic [7:0] base);
    for (int i = 0; i < K; i++) exp_q.push_back({base + 8'(i), (i == 0), 1'b0});
    for (int i = 0; i < N - K; i++) exp_q.push_back({8'hA1 + 8'(i), 1'b0, (i == N - K - 1)});
  endtask

  task automatic send_cw(input logic [7:0] base, input bit gap);
    push_cw(base);
    for (int i = 0; i < K; i++) begin
      send_sym(base + 8'(i));
      if (gap && i < K - 1) begin
        @(negedge clk);
        in_valid = 1'b0;
      end
    end
  endtask

  task automatic drain();
    int guard = 0;
    @(negedge clk);
    in_valid = 1'b0;
    while (exp_q.size() != 0 || out_valid) begin
      @(negedge clk);
      #3;
      guard++;
      if (guard > 300) begin
        check_eq("drain_timeout", 32'd1, 32'd0);
        exp_q.delete();
        break;
      end
    end
  endtask

  initial begin
    int en0, fi0, sh0, s0, f0;
    rst = 1'b1; in_valid = 1'b0; in_data = 8'd0;
    repeat (2) @(posedge clk);
    @(negedge clk); #2;
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_enc_en", {31'd0, enc_en}, 32'd0);
    check_eq("rst_cw_count", {16'd0, cw_count}, 32'd0);
    check_eq("rst_out_data", {22'd0, out_data, out_sop, out_eop}, 32'd0);
    rst = 1'b0;

    // single codeword
    en0 = en_cnt; fi0 = fi_cnt; sh0 = sh_cnt; s0 = sop_cyc_q.size();
    send_cw(8'h01, 1'b0);
    drain();
    check_eq("t1_en", en_cnt - en0, 32'd11);
    check_eq("t1_first", fi_cnt - fi0, 32'd1);
    check_eq("t1_shift", sh_cnt - sh0, 32'd4);
    check_eq("t1_span", eop_cyc_q[eop_cyc_q.size()-1] - sop_cyc_q[s0], 32'd14);
    check_eq("t1_cw_count", {16'd0, cw_count}, 32'd1);

    // three back-to-back codewords
    en0 = en_cnt; sh0 = sh_cnt; s0 = sop_cyc_q.size(); f0 = first_at_q.size();
    send_cw(8'h10, 1'b0);
    send_cw(8'h40, 1'b0);
    send_cw(8'h70, 1'b0);
    drain();
    check_eq("t2_span", eop_cyc_q[eop_cyc_q.size()-1] - sop_cyc_q[s0], 32'd44);
    check_eq("t2_first0", first_at_q[f0] - (en0 + sh0), 32'd0);
    check_eq("t2_first1", first_at_q[f0+1] - (en0 + sh0), 32'd15);
    check_eq("t2_first2", first_at_q[f0+2] - (en0 + sh0), 32'd30);
    check_eq("t2_cw_count", {16'd0, cw_count}, 32'd4);

    // backpressure on beats 5 and 12
    en0 = en_cnt; sh0 = sh_cnt;
    bp_mode = 1'b1;
    send_cw(8'h01, 1'b0);
    drain();
    bp_mode = 1'b0;
    check_eq("t3_en", en_cnt - en0, 32'd11);
    check_eq("t3_shift", sh_cnt - sh0, 32'd4);
    check_eq("t3_cw_count", {16'd0, cw_count}, 32'd5);

    // input bubbles
    s0 = sop_cyc_q.size();
    send_cw(8'h21, 1'b1);
    drain();
    check_eq("t4_span", eop_cyc_q[eop_cyc_q.size()-1] - sop_cyc_q[s0], 32'd24);
    check_eq("t4_cw_count", {16'd0, cw_count}, 32'd6);

    // reset after six message symbols
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back({8'h50 + 8'(i), (i == 0), 1'b0});
      send_sym(8'h50 + 8'(i));
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk); #2;
    check_eq("mr_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("mr_busy", {31'd0, busy}, 32'd0);
    check_eq("mr_cw_count", {16'd0, cw_count}, 32'd0);
    check_eq("mr_leftover", exp_q.size(), 32'd0);
    rst = 1'b0;
    fi0 = fi_cnt;
    send_cw(8'h60, 1'b0);
    drain();
    check_eq("mr_first", fi_cnt - fi0, 32'd1);
    check_eq("mr_cw_count2", {16'd0, cw_count}, 32'd1);

    // cw_count wrap
    @(negedge clk);
    force dut.cw_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.cw_count_q;
    #2;
    check_eq("wrap_pre", {16'd0, cw_count}, 32'hFFFF);
    send_cw(8'h90, 1'b0);
    drain();
    check_eq("wrap_post", {16'd0, cw_count}, 32'd0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", check_cnt, err_cnt);
    $finish;
  end
endmodule
